scan_scheduler: RTL and testbench

- Time-shares the board's display and keypad I/O from a single clock domain, replacing the divided clocks with one-cycle enable ticks.
- Generates the 7-segment scan tick (`fnd_tick`) and the keypad scan tick (`sw_tick`).
- Multiplexes the digits of the 7-segment display (FND) and inserts anti-ghosting blank intervals between them.
- Scans the 4x4 keypad column by column and reports each new key press once.
- Sits between the top level (digit patterns in, key codes out) and the board pins.

---
 rtl/scan_pkg.sv | 17 +
 rtl/tick_gen.sv | 28 ++
 rtl/scan_scheduler.sv | 144 ++++++++++++++
 tb/tb_scan_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the display/keypad scan scheduler.
package scan_pkg;

  typedef enum logic [0:0] {
    F_BLANK = 1'b0,
    F_SHOW  = 1'b1
  } fnd_state_t;

  // Held-code register layout: {valid, code[3:0]}
  localparam logic [4:0] KEY_NONE = 5'b0_0000;

  localparam int FND_DIV_DEF   = 131072;
  localparam int SW_DIV_DEF    = 2097152;
  localparam int DIGITS_DEF    = 8;
  localparam int BLANK_CYC_DEF = 16;

endpackage

// File: rtl/tick_gen.sv
// Free-running 0..DIV-1 counter producing a one-cycle enable tick at DIV-1.
module tick_gen
  import scan_pkg::*;
#(
  parameter int DIV = FND_DIV_DEF
) (
  input  logic clock_50m,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock_50m) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/scan_scheduler.sv
// Time-shares FND digit multiplexing and 4x4 keypad scanning from one clock.
//   state   | meaning
//   F_BLANK | all digits off, blank counter running down to 0
//   F_SHOW  | current digit driven with its latched segment byte until fnd_tick
module scan_scheduler
  import scan_pkg::*;
#(
  parameter int FND_DIV   = FND_DIV_DEF,
  parameter int SW_DIV    = SW_DIV_DEF,
  parameter int DIGITS    = DIGITS_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic                clock_50m,
  input  logic                rst,
  input  logic                en,
  input  logic [DIGITS*8-1:0] digit_data,
  output logic [7:0]          seg_out,
  output logic [DIGITS-1:0]   digit_sel,
  input  logic [3:0]          key_row,
  output logic [3:0]          key_col,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                fnd_tick,
  output logic                sw_tick
);

  localparam int                BW           = $clog2(BLANK_CYC + 1);
  localparam logic [BW-1:0]     BLANK_RELOAD = BW'(BLANK_CYC - 1);
  localparam int                IW           = $clog2(DIGITS);
  localparam logic [IW-1:0]     LAST_IDX     = IW'(DIGITS - 1);

  tick_gen #(.DIV(FND_DIV)) u_fnd_tick (
    .clock_50m (clock_50m),
    .rst       (rst),
    .en        (en),
    .tick      (fnd_tick)
  );

  tick_gen #(.DIV(SW_DIV)) u_sw_tick (
    .clock_50m (clock_50m),
    .rst       (rst),
    .en        (en),
    .tick      (sw_tick)
  );

  fnd_state_t    fnd_state;
  logic [BW-1:0] blank_cnt;
  logic [IW-1:0] digit_idx;
  logic [7:0]    cur_byte;

  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IW'(i)) cur_byte = digit_data[i*8 +: 8];
    end
  end

  always_ff @(posedge clock_50m) begin
    if (rst) begin
      fnd_state <= F_BLANK;
      blank_cnt <= BLANK_RELOAD;
      digit_idx <= '0;
      seg_out   <= '0;
      digit_sel <= '0;
    end else if (!en) begin
      // Pause: go dark and restart the blank interval, keep the digit position
      fnd_state <= F_BLANK;
      blank_cnt <= BLANK_RELOAD;
      seg_out   <= '0;
      digit_sel <= '0;
    end else begin
      case (fnd_state)
        F_BLANK: begin
          if (blank_cnt == '0) begin
            fnd_state <= F_SHOW;
            seg_out   <= cur_byte;
            digit_sel <= DIGITS'(1) << digit_idx;
          end else begin
            blank_cnt <= blank_cnt - 1'b1;
          end
        end
        F_SHOW: begin
          if (fnd_tick) begin
            fnd_state <= F_BLANK;
            blank_cnt <= BLANK_RELOAD;
            seg_out   <= '0;
            digit_sel <= '0;
            digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
          end
        end
        default: fnd_state <= F_BLANK;
      endcase
    end
  end

  logic [1:0] col_idx;
  logic [1:0] miss_cnt;
  logic [4:0] held_code;
  logic [1:0] row_idx;
  logic       key_hit;
  logic [4:0] cand;

  // Lowest pressed row takes priority
  always_comb begin
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (key_row[r]) row_idx = 2'(r);
    end
  end

  assign key_hit = |key_row;
  assign cand    = {1'b1, row_idx, col_idx};
  assign key_col = 4'b0001 << col_idx;

  always_ff @(posedge clock_50m) begin
    if (rst) begin
      col_idx   <= 2'd0;
      miss_cnt  <= 2'd0;
      held_code <= KEY_NONE;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (sw_tick) begin
        col_idx <= col_idx + 1'b1;
        if (key_hit) begin
          miss_cnt <= 2'd0;
          if (cand != held_code) begin
            held_code <= cand;
            key_code  <= cand[3:0];
            key_valid <= 1'b1;
          end
        end else if (miss_cnt == 2'd3) begin
          // A whole sweep without any key releases the held code
          miss_cnt  <= 2'd0;
          held_code <= KEY_NONE;
        end else begin
          miss_cnt <= miss_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_scheduler.sv
// Randomized scoreboard bench for scan_scheduler against a behavioural model.
module tb_scan_scheduler;

  localparam int FND_DIV   = 8;
  localparam int SW_DIV    = 32;
  localparam int DIGITS    = 4;
  localparam int BLANK_CYC = 2;

  logic        clock_50m = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [31:0] digit_data = 32'hA1B2C3D4;
  logic [7:0]  seg_out;
  logic [3:0]  digit_sel;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        fnd_tick;
  logic        sw_tick;
  logic [15:0] pressed = 16'h0;

  always #5 clock_50m = ~clock_50m;

  // Keypad matrix: key r*4+c connects row r to column c
  always_comb begin
    key_row = 4'b0000;
    for (int r = 0; r < 4; r++) key_row[r] = |(pressed[r*4 +: 4] & key_col);
  end

  scan_scheduler #(
    .FND_DIV(FND_DIV), .SW_DIV(SW_DIV), .DIGITS(DIGITS), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clock_50m  (clock_50m),
    .rst        (rst),
    .en         (en),
    .digit_data (digit_data),
    .seg_out    (seg_out),
    .digit_sel  (digit_sel),
    .key_row    (key_row),
    .key_col    (key_col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .fnd_tick   (fnd_tick),
    .sw_tick    (sw_tick)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pulse_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int sel; int seg; int cyc; } show_t;
  typedef struct { int code; int cyc; } key_t;
  show_t show_q[$];
  int    exit_q[$];
  key_t  key_q[$];

  // Behavioural model state
  int m_fcnt = 0, m_scnt = 0;
  bit showing = 1'b0;
  int blank_rem = BLANK_CYC;
  int idx = 0;
  int m_col = 0;
  bit held_v = 1'b0;
  int held_code = 0;
  int misses = 0;

  task automatic model_step();
    bit ft, st, found;
    int code;
    cyc++;
    if (rst) begin
      if (showing) exit_q.push_back(cyc);
      showing = 0; blank_rem = BLANK_CYC; idx = 0;
      m_fcnt = 0; m_scnt = 0; m_col = 0; held_v = 0; misses = 0;
      return;
    end
    ft = en && (m_fcnt == FND_DIV - 1);
    st = en && (m_scnt == SW_DIV - 1);
    if (en) begin
      m_fcnt = (m_fcnt + 1) % FND_DIV;
      m_scnt = (m_scnt + 1) % SW_DIV;
    end
    if (!en) begin
      if (showing) exit_q.push_back(cyc);
      showing = 0;
      blank_rem = BLANK_CYC;
    end else if (!showing) begin
      blank_rem--;
      if (blank_rem == 0) begin
        showing = 1;
        show_q.push_back('{sel: 1 << idx, seg: (digit_data >> (8 * idx)) & 32'hFF, cyc: cyc});
      end
    end else if (ft) begin
      showing = 0;
      exit_q.push_back(cyc);
      blank_rem = BLANK_CYC;
      idx = (idx + 1) % DIGITS;
    end
    if (st) begin
      found = 0; code = 0;
      for (int r = 0; r < 4; r++) begin
        if (!found && pressed[r*4 + m_col]) begin found = 1; code = r * 4 + m_col; end
      end
      if (found) begin
        misses = 0;
        if (!held_v || held_code != code) begin
          held_v = 1; held_code = code;
          key_q.push_back('{code: code, cyc: cyc});
        end
      end else begin
        misses++;
        if (misses == 4) begin held_v = 0; misses = 0; end
      end
      m_col = (m_col + 1) % 4;
    end
  endtask

  initial forever begin
    @(posedge clock_50m);
    model_step();
  end

  // Monitor
  initial begin
    logic [3:0] prev_sel;
    logic [7:0] prev_seg;
    show_t s;
    key_t  k;
    prev_sel = 4'b0; prev_seg = 8'h0;
    forever begin
      @(negedge clock_50m);
      check("fnd_tick", fnd_tick, en && (m_fcnt == FND_DIV - 1));
      check("sw_tick", sw_tick, en && (m_scnt == SW_DIV - 1));
      check("key_col", key_col, 32'(1 << m_col));
      if (digit_sel == 4'b0) check("blank_seg", seg_out, 0);
      if (prev_sel == 4'b0 && digit_sel != 4'b0) begin
        if (show_q.size() == 0) check("show_unexpected", digit_sel, 0);
        else begin
          s = show_q.pop_front();
          check("show_sel", digit_sel, s.sel);
          check("show_seg", seg_out, s.seg);
          check("show_cycle", cyc, s.cyc);
        end
      end else if (prev_sel != 4'b0 && digit_sel == 4'b0) begin
        if (exit_q.size() == 0) check("exit_unexpected", 1, 0);
        else check("exit_cycle", cyc, exit_q.pop_front());
      end else if (prev_sel != 4'b0) begin
        check("show_sel_stable", digit_sel, prev_sel);
        check("show_seg_stable", seg_out, prev_seg);
      end
      if (show_q.size() > 0 && show_q[0].cyc < cyc) begin
        s = show_q.pop_front();
        check("show_missing", 0, s.sel);
      end
      if (exit_q.size() > 0 && exit_q[0] < cyc) check("exit_missing", 0, exit_q.pop_front());
      if (key_valid) begin
        pulse_cnt++;
        if (key_q.size() == 0) check("key_unexpected", key_code, 32'hFFFF);
        else begin
          k = key_q.pop_front();
          check("key_code", key_code, k.code);
          check("key_cycle", cyc, k.cyc);
        end
      end
      if (key_q.size() > 0 && key_q[0].cyc < cyc) begin
        k = key_q.pop_front();
        check("key_missing", 0, k.code + 1);
      end
      prev_sel = digit_sel;
      prev_seg = seg_out;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock_50m);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"}, seg_out, 0);
    check({tag, "_sel"}, digit_sel, 0);
    check({tag, "_col"}, key_col, 4'b0001);
    check({tag, "_code"}, key_code, 0);
    check({tag, "_valid"}, key_valid, 0);
  endtask

  initial begin
    int first_tick, first_sel, n, p0, sel_at_first;
    first_tick = 0; first_sel = 0; sel_at_first = 0;

    // 1: reset and start-up timing
    repeat (3) @(posedge clock_50m);
    #2 rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock_50m);
      if (k == 1) begin
        check_reset_outputs("reset");
        check("reset_fnd_tick", fnd_tick, 0);
        check("reset_sw_tick", sw_tick, 0);
      end
      if (first_tick == 0 && fnd_tick) first_tick = k;
      if (first_sel == 0 && digit_sel != 0) begin first_sel = k; sel_at_first = digit_sel; end
    end
    check("first_fnd_tick_cycle", first_tick, 8);
    check("first_sel_cycle", first_sel, 3);
    check("first_sel_value", sel_at_first, 4'b0001);

    // 2: digit scan over several rotations
    wait_cyc(80);

    // 3: press and hold key 10, release, press again
    p0 = pulse_cnt;
    pressed = 16'h0400;
    wait_cyc(4 * 4 * SW_DIV);
    check("hold_pulses", pulse_cnt - p0, 1);
    check("hold_code", key_code, 10);
    pressed = 16'h0;
    wait_cyc(5 * SW_DIV);
    pressed = 16'h0400;
    wait_cyc(5 * SW_DIV);
    check("repress_pulses", pulse_cnt - p0, 2);

    // 4: two rows in column 1, lowest row wins
    pressed = 16'h0220;
    wait_cyc(5 * SW_DIV);
    check("multi_row_code", key_code, 5);

    // 5: enable pause on digit 2
    for (n = 0; n < 200; n++) begin
      wait_cyc(1);
      if (digit_sel == 4'b0100) break;
    end
    check("find_digit2", n < 200, 1);
    en = 1'b0;
    wait_cyc(1);
    check("pause_sel", digit_sel, 0);
    check("pause_tick", {fnd_tick, sw_tick}, 0);
    wait_cyc(4);
    en = 1'b1;
    for (n = 0; n < 10; n++) begin
      wait_cyc(1);
      if (digit_sel != 4'b0) break;
    end
    check("resume_blank_len", n + 1, BLANK_CYC);
    check("resume_digit", digit_sel, 4'b0100);
    wait_cyc(40);

    // 6: reset mid-sweep with a held key
    pressed = 16'h0400;
    wait_cyc(5 * SW_DIV + 17);
    p0 = pulse_cnt;
    rst = 1'b1;
    wait_cyc(1);
    check_reset_outputs("midreset");
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(5 * SW_DIV);
    check("post_reset_pulse", pulse_cnt - p0, 1);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0:       pressed = 16'h0;
        1, 2:    pressed = 16'(1 << $urandom_range(0, 15));
        default: pressed = 16'($urandom());
      endcase
      if ($urandom_range(0, 2) == 0) digit_data = $urandom();
      if ($urandom_range(0, 4) == 0) begin
        en = 1'b0;
        wait_cyc($urandom_range(1, 10));
        en = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        wait_cyc($urandom_range(1, 3));
        rst = 1'b0;
      end
      wait_cyc($urandom_range(20, 300));
    end

    wait_cyc(5);
    @(negedge clock_50m);
    #1;
    check("show_q_drained", show_q.size(), 0);
    check("exit_q_drained", exit_q.size(), 0);
    check("key_q_drained", key_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
